bound_reduce_sequencer: RTL and testbench

Sequences one shared signed compare slice over a stream of candidate bounds (value + activation) belonging to one variable's constraints. Produces the running maximum (lower bound) and minimum (upper bound) of all active terms, each with a validity flag. Sits between the constraint-coefficient fetch logic and the MCMC proposal sampler, replacing a wide combinational max/min tree with a serial, handshaked reduction.

---
 rtl/bound_reduce_pkg.sv | 21 ++
 rtl/bound_reduce_sequencer_fold.sv | 37 +++
 rtl/bound_reduce_sequencer.sv | 129 ++++++++++++
 tb/tb_bound_reduce_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bound_reduce_pkg.sv
// Shared definitions for the bound reduction sequencer.
// Optional feature macro used by the top: BOUND_REDUCE_COUNT_EN.
//   state_t      : sequencer states (IDLE, ACCUM, DONE), 2-bit encoding
//   DEFAULT_*    : default candidate width and frame length
//   cnt_width()  : width of a counter able to hold 0..num_terms
package bound_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_NUMBER_SIZE = 4;
  localparam int unsigned DEFAULT_NUM_TERMS   = 8;

  function automatic int unsigned cnt_width(input int unsigned num_terms);
    return $clog2(num_terms + 1);
  endfunction

endpackage

// File: rtl/bound_reduce_sequencer_fold.sv
// bound_fold_slice: combinational fold of one candidate into the running
// max and min accumulators.
//   acc_max/acc_max_active : running maximum and its validity
//   acc_min/acc_min_active : running minimum and its validity
//   number/active          : incoming candidate and its participation flag
//   max*/min*              : folded results
// An inactive candidate never replaces the accumulator; an active one replaces
// an inactive accumulator, otherwise it must be strictly better (ties keep the
// earliest term).
module bound_fold_slice #(
  parameter int unsigned NUMBER_SIZE = 4
) (
  input  logic signed [NUMBER_SIZE-1:0] acc_max,
  input  logic                          acc_max_active,
  input  logic signed [NUMBER_SIZE-1:0] acc_min,
  input  logic                          acc_min_active,
  input  logic signed [NUMBER_SIZE-1:0] number,
  input  logic                          active,
  output logic signed [NUMBER_SIZE-1:0] max,
  output logic                          max_active,
  output logic signed [NUMBER_SIZE-1:0] min,
  output logic                          min_active
);

  logic take_max;
  logic take_min;

  always_comb begin
    take_max   = active && (!acc_max_active || (number > acc_max));
    take_min   = active && (!acc_min_active || (number < acc_min));
    max        = take_max ? number : acc_max;
    min        = take_min ? number : acc_min;
    max_active = acc_max_active | active;
    min_active = acc_min_active | active;
  end

endmodule

// File: rtl/bound_reduce_sequencer.sv
// bound_reduce_sequencer: serial handshaked max/min reduction over a frame of
// NUM_TERMS signed candidate bounds using one shared fold slice.
// Optional feature macro: BOUND_REDUCE_COUNT_EN adds res_active_count.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a frame (sampled in IDLE only)
//   in_valid/in_ready   : candidate handshake; in_number, in_active payload
//   busy                : high in ACCUM and DONE
//   res_valid/res_ready : result handshake, result held until accepted
//   res_max/res_min     : signed max/min of active terms, with *_active flags
//   res_active_count    : (optional) number of active terms in the frame
module bound_reduce_sequencer
  import bound_reduce_pkg::*;
#(
  parameter int unsigned NUMBER_SIZE = DEFAULT_NUMBER_SIZE,
  parameter int unsigned NUM_TERMS   = DEFAULT_NUM_TERMS,
  parameter int unsigned CNT_W       = cnt_width(NUM_TERMS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [NUMBER_SIZE-1:0] in_number,
  input  logic                          in_active,
  output logic                          busy,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic signed [NUMBER_SIZE-1:0] res_max,
  output logic                          res_max_active,
  output logic signed [NUMBER_SIZE-1:0] res_min,
`ifdef BOUND_REDUCE_COUNT_EN
  output logic                          res_min_active,
  output logic [CNT_W-1:0]              res_active_count
`else
  output logic                          res_min_active
`endif
);

  state_t                   state;
  state_t                   state_next;
  logic [CNT_W-1:0]         term_cnt;
  logic                     accept;
  logic                     term_last;
  logic signed [NUMBER_SIZE-1:0] fold_max;
  logic signed [NUMBER_SIZE-1:0] fold_min;
  logic                     fold_max_active;
  logic                     fold_min_active;

  always_comb begin
    accept    = (state == ACCUM) && in_valid;
    term_last = (term_cnt == CNT_W'(NUM_TERMS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    res_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && term_last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  bound_fold_slice #(
    .NUMBER_SIZE(NUMBER_SIZE)
  ) u_fold (
    .acc_max        (res_max),
    .acc_max_active (res_max_active),
    .acc_min        (res_min),
    .acc_min_active (res_min_active),
    .number         (in_number),
    .active         (in_active),
    .max            (fold_max),
    .max_active     (fold_max_active),
    .min            (fold_min),
    .min_active     (fold_min_active)
  );

  // The result registers double as the accumulators: they clear when a frame
  // starts and otherwise hold, so results stay visible through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_cnt       <= '0;
      res_max        <= '0;
      res_max_active <= 1'b0;
      res_min        <= '0;
      res_min_active <= 1'b0;
    end else if ((state == IDLE) && start) begin
      term_cnt       <= '0;
      res_max        <= '0;
      res_max_active <= 1'b0;
      res_min        <= '0;
      res_min_active <= 1'b0;
    end else if (accept) begin
      term_cnt       <= term_cnt + CNT_W'(1);
      res_max        <= fold_max;
      res_max_active <= fold_max_active;
      res_min        <= fold_min;
      res_min_active <= fold_min_active;
    end
  end

`ifdef BOUND_REDUCE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       res_active_count <= '0;
    else if ((state == IDLE) && start) res_active_count <= '0;
    else if (accept && in_active)     res_active_count <= res_active_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_bound_reduce_sequencer.sv
// Testbench for bound_reduce_sequencer (NUM_TERMS=4, NUMBER_SIZE=4).
// Directed table vectors, a stall/hold sequence, reset during ACCUM and
// randomized frames checked against a reference reduction model.
module tb_bound_reduce_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned NT = 4;
  localparam int unsigned CW = $clog2(NT + 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [NS-1:0] in_number;
  logic                 in_active;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic signed [NS-1:0] res_max;
  logic                 res_max_active;
  logic signed [NS-1:0] res_min;
  logic                 res_min_active;
`ifdef BOUND_REDUCE_COUNT_EN
  logic [CW-1:0]        res_active_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  bound_reduce_sequencer #(
    .NUMBER_SIZE(NS),
    .NUM_TERMS  (NT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_number      (in_number),
    .in_active      (in_active),
    .busy           (busy),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_max        (res_max),
    .res_max_active (res_max_active),
    .res_min        (res_min),
`ifdef BOUND_REDUCE_COUNT_EN
    .res_min_active (res_min_active),
    .res_active_count(res_active_count)
`else
    .res_min_active (res_min_active)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  typedef struct {
    logic [NT-1:0][NS-1:0] vals;
    logic [NT-1:0]         acts;
    int                    gap_at;
    int                    gap_len;
    int                    ready_delay;
    bit                    start_in_done;
    int                    exp_lat;
    int                    exp_max;
    int                    exp_min;
    int                    exp_act;
    int                    exp_cnt;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Reference reduction: plain max/min over the active terms of a frame.
  function automatic void model(input logic [NT-1:0][NS-1:0] vals,
                                input logic [NT-1:0] acts,
                                output int mx, output int mn,
                                output int act, output int cnt);
    int v;
    mx = 0; mn = 0; cnt = 0;
    for (int i = 0; i < int'(NT); i++) begin
      if (acts[i]) begin
        v = int'($signed(vals[i]));
        if (cnt == 0) begin
          mx = v; mn = v;
        end else begin
          if (v > mx) mx = v;
          if (v < mn) mn = v;
        end
        cnt++;
      end
    end
    act = (cnt > 0) ? 1 : 0;
  endfunction

  task automatic check_results(input int mx, input int mn, input int act, input int cnt);
    check("res_max", int'(res_max), mx);
    check("res_min", int'(res_min), mn);
    check("res_max_active", int'(res_max_active), act);
    check("res_min_active", int'(res_min_active), act);
`ifdef BOUND_REDUCE_COUNT_EN
    check("res_active_count", int'(res_active_count), cnt);
`else
    if (cnt < 0) check("count_range", cnt, 0);
`endif
  endtask

  // Starts a frame and streams NT terms; returns at the negedge where
  // res_valid is first seen. lat counts cycles from the start cycle (cycle 0).
  task automatic run_frame(input logic [NT-1:0][NS-1:0] vals, input logic [NT-1:0] acts,
                           input int gap_at, input int gap_len, input bit rnd_gaps,
                           output int lat);
    int  cyc;
    int  idx;
    bit  gap;
    bit  drv;
    bit  hs;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    idx = 0;
    while (!res_valid && cyc < 200) begin
      gap = rnd_gaps ? ($urandom_range(0, 2) == 0) : (cyc >= gap_at && cyc < gap_at + gap_len);
      drv = (idx < int'(NT)) && !gap;
      in_valid  = drv;
      in_number = drv ? vals[idx] : NS'($urandom);
      in_active = drv ? acts[idx] : 1'($urandom);
      hs = drv && in_ready;
      @(negedge clk);
      cyc++;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    lat = cyc;
    check("res_valid_seen", int'(res_valid), 1);
    check("terms_consumed", idx, int'(NT));
  endtask

  // Holds off acceptance, checking the results stay put, then accepts.
  task automatic finish_frame(input int mx, input int mn, input int act, input int cnt,
                              input int ready_delay, input bit start_in_done);
    for (int d = 0; d < ready_delay; d++) begin
      check_results(mx, mn, act, cnt);
      check("done_in_ready", int'(in_ready), 0);
      if (start_in_done && d == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    check_results(mx, mn, act, cnt);
    check("done_res_valid", int'(res_valid), 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_res_valid", int'(res_valid), 0);
    check("idle_busy", int'(busy), 0);
    // Results persist in IDLE until the next frame starts.
    check("idle_hold_max", int'(res_max), mx);
  endtask

  initial begin
    int lat;
    int mx, mn, act, cnt;
    logic [NT-1:0][NS-1:0] rv;
    logic [NT-1:0]         ra;

    // {3,-2,7,-8} all active, back-to-back
    tbl[0] = '{vals: {4'h8, 4'h7, 4'hE, 4'h3}, acts: 4'b1111, gap_at: 0, gap_len: 0,
               ready_delay: 0, start_in_done: 1'b0, exp_lat: 5,
               exp_max: 7, exp_min: -8, exp_act: 1, exp_cnt: 4};
    // {5,-1,6,2} actives {0,1,0,1}
    tbl[1] = '{vals: {4'h2, 4'h6, 4'hF, 4'h5}, acts: 4'b1010, gap_at: 0, gap_len: 0,
               ready_delay: 1, start_in_done: 1'b0, exp_lat: 5,
               exp_max: 2, exp_min: -1, exp_act: 1, exp_cnt: 2};
    // {7,7,-8,0} all inactive
    tbl[2] = '{vals: {4'h0, 4'h8, 4'h7, 4'h7}, acts: 4'b0000, gap_at: 0, gap_len: 0,
               ready_delay: 0, start_in_done: 1'b0, exp_lat: 5,
               exp_max: 0, exp_min: 0, exp_act: 0, exp_cnt: 0};
    // ties {-3 a, -3 a, 0 i, -3 a}
    tbl[3] = '{vals: {4'hD, 4'h0, 4'hD, 4'hD}, acts: 4'b1011, gap_at: 0, gap_len: 0,
               ready_delay: 0, start_in_done: 1'b0, exp_lat: 5,
               exp_max: -3, exp_min: -3, exp_act: 1, exp_cnt: 3};
    // {1,-4,5,0}: 3-cycle in_valid gap mid-frame, 4-cycle hold, start in DONE
    tbl[4] = '{vals: {4'h0, 4'h5, 4'hC, 4'h1}, acts: 4'b1111, gap_at: 3, gap_len: 3,
               ready_delay: 4, start_in_done: 1'b1, exp_lat: 8,
               exp_max: 5, exp_min: -4, exp_act: 1, exp_cnt: 4};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_number = '0;
    in_active = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check_results(0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].vals, tbl[i].acts, tbl[i].gap_at, tbl[i].gap_len, 1'b0, lat);
      check("latency", lat, tbl[i].exp_lat);
      finish_frame(tbl[i].exp_max, tbl[i].exp_min, tbl[i].exp_act, tbl[i].exp_cnt,
                   tbl[i].ready_delay, tbl[i].start_in_done);
      @(negedge clk);
      check("no_restart_busy", int'(busy), 0);
    end

    // Reset asserted during ACCUM after two terms: outputs clear immediately.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_number = 4'sd6; in_active = 1'b1;
    @(negedge clk);
    in_number = -4'sd7;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", int'(in_ready), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_res_valid", int'(res_valid), 0);
    check_results(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rv = {4'h1, 4'h3, 4'h2, 4'h9};
    ra = 4'b0110;
    model(rv, ra, mx, mn, act, cnt);
    run_frame(rv, ra, 0, 0, 1'b0, lat);
    check("post_rst_latency", lat, 5);
    finish_frame(mx, mn, act, cnt, 0, 1'b0);

    // Randomized frames with random in_valid gaps and result back-pressure.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < int'(NT); i++) begin
        rv[i] = NS'($urandom);
        ra[i] = 1'($urandom);
      end
      model(rv, ra, mx, mn, act, cnt);
      run_frame(rv, ra, 0, 0, 1'b1, lat);
      finish_frame(mx, mn, act, cnt, int'($urandom_range(0, 2)), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
